// File: rtl/ila_capture_if.sv
// Probe, trigger-setup, readout and status bundle
// for the ila_capture logic analyser core.
interface ila_capture_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic          probe0;
    logic [3:0]    probe1;
    logic          ARM;
    logic [4:0]    TRIG_MASK;
    logic [4:0]    TRIG_VALUE;
    logic [AW-1:0] RD_ADDR;
    logic [4:0]    RD_DATA;
    logic          ARMED;
    logic          TRIGGERED;
    logic          DONE;

    modport master (
        output probe0, probe1, ARM,
        output TRIG_MASK, TRIG_VALUE, RD_ADDR,
        input  RD_DATA, ARMED, TRIGGERED, DONE
    );

    modport slave (
        input  probe0, probe1, ARM,
        input  TRIG_MASK, TRIG_VALUE, RD_ADDR,
        output RD_DATA, ARMED, TRIGGERED, DONE
    );
endinterface

// File: rtl/ila_capture.sv
// Integrated logic analyser: circular capture of a 5-bit probe
// around a masked trigger, then registered readout from the oldest sample.
module ila_capture #(
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    ila_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] oldest_q, oldest_d;
    logic [4:0]    rd_data_q;
    logic [4:0]    mem [DEPTH];
    logic [4:0]    sample;
    logic [AW-1:0] raddr;
    logic          hit;
    logic          we;

    assign sample = {bus.probe0, bus.probe1};
    assign hit    = ((sample ^ bus.TRIG_VALUE) & bus.TRIG_MASK) == 5'd0;
    assign raddr  = oldest_q + bus.RD_ADDR;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            cnt_q    <= '0;
            oldest_q <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            oldest_q <= oldest_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        cnt_d    = cnt_q;
        oldest_d = oldest_q;
        we       = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.ARM) begin
                    state_d = S_PRETRIG;
                    wptr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_PRETRIG: begin
                we     = 1'b1;
                wptr_d = wptr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                we     = 1'b1;
                wptr_d = wptr_q + 1'b1;
                if (hit) begin
                    state_d = S_POST;
                    cnt_d   = '0;
                end
            end
            S_POST: begin
                we     = 1'b1;
                wptr_d = wptr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                // Slot after the final write is the oldest surviving sample
                if (cnt_q == POST_LAST) begin
                    state_d  = S_DONE;
                    oldest_d = wptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wptr_q] <= sample;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[raddr];
        end
    end

    assign bus.RD_DATA   = rd_data_q;
    assign bus.ARMED     = (state_q == S_PRETRIG) || (state_q == S_WAIT);
    assign bus.TRIGGERED = (state_q == S_POST) || (state_q == S_DONE);
    assign bus.DONE      = (state_q == S_DONE);
endmodule

// File: tb/tb_ila_capture.sv
// Directed bench for ila_capture: reset, masked and unmasked
// trigger captures, readout, aborts and ARM handling.
module tb_ila_capture;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    ila_capture_if #(.DEPTH(64)) bus ();

    ila_capture #(.DEPTH(64), .PRE_TRIG(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET          = 1'b1;
        bus.probe0     = 1'b0;
        bus.probe1     = 4'd0;
        bus.ARM        = 1'b0;
        bus.TRIG_MASK  = 5'd0;
        bus.TRIG_VALUE = 5'd0;
        bus.RD_ADDR    = 6'd0;
        #2;
        checks++;
        if ({bus.ARMED, bus.TRIGGERED, bus.DONE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.ARMED, bus.TRIGGERED, bus.DONE});
        end
        checks++;
        if (bus.RD_DATA !== 5'h00) begin
            errors++;
            $display("FAIL reset_rd got %h want 00", bus.RD_DATA);
        end
        tick();
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if ({bus.ARMED, bus.TRIGGERED, bus.DONE} !== 3'b000) begin
            errors++;
            $display("FAIL idle_flags got %b want 000",
                     {bus.ARMED, bus.TRIGGERED, bus.DONE});
        end
    endtask

    task automatic test_basic();
        int done_k = 0;
        bus.TRIG_MASK  = 5'h0F;
        bus.TRIG_VALUE = 5'h05;
        bus.probe0     = 1'b0;
        bus.probe1     = 4'd0;
        bus.ARM        = 1'b1;
        tick();
        bus.ARM = 1'b0;
        checks++;
        if ({bus.ARMED, bus.TRIGGERED} !== 2'b10) begin
            errors++;
            $display("FAIL basic_arm got %b want 10",
                     {bus.ARMED, bus.TRIGGERED});
        end
        for (int k = 1; k <= 200; k++) begin
            bus.probe1 = 4'((k - 1) % 16);
            tick();
            if (k == 21) begin
                checks++;
                if ({bus.ARMED, bus.TRIGGERED} !== 2'b10) begin
                    errors++;
                    $display("FAIL basic_pretrig got %b want 10",
                             {bus.ARMED, bus.TRIGGERED});
                end
            end
            if (k == 22) begin
                checks++;
                if ({bus.ARMED, bus.TRIGGERED} !== 2'b01) begin
                    errors++;
                    $display("FAIL basic_trig got %b want 01",
                             {bus.ARMED, bus.TRIGGERED});
                end
            end
            if (bus.DONE === 1'b1) begin
                done_k = k;
                break;
            end
        end
        checks++;
        if (done_k != 69) begin
            errors++;
            $display("FAIL basic_done_edge got %0d want 69", done_k);
        end
        bus.RD_ADDR = 6'd16;
        tick();
        checks++;
        if (bus.RD_DATA !== 5'h05) begin
            errors++;
            $display("FAIL basic_rd16 got %h want 05", bus.RD_DATA);
        end
        bus.RD_ADDR = 6'd15;
        tick();
        checks++;
        if (bus.RD_DATA !== 5'h04) begin
            errors++;
            $display("FAIL basic_rd15 got %h want 04", bus.RD_DATA);
        end
        bus.RD_ADDR = 6'd0;
        tick();
        checks++;
        if (bus.RD_DATA !== 5'h05) begin
            errors++;
            $display("FAIL basic_rd0 got %h want 05", bus.RD_DATA);
        end
        bus.RD_ADDR = 6'd17;
        tick();
        checks++;
        if (bus.RD_DATA !== 5'h06) begin
            errors++;
            $display("FAIL basic_rd17 got %h want 06", bus.RD_DATA);
        end
    endtask

    task automatic test_async_reset();
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if ({bus.ARMED, bus.TRIGGERED, bus.DONE} !== 3'b000) begin
            errors++;
            $display("FAIL async_flags got %b want 000",
                     {bus.ARMED, bus.TRIGGERED, bus.DONE});
        end
        checks++;
        if (bus.RD_DATA !== 5'h00) begin
            errors++;
            $display("FAIL async_rd got %h want 00", bus.RD_DATA);
        end
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_mask0();
        bus.TRIG_MASK  = 5'h00;
        bus.TRIG_VALUE = 5'h1F;
        bus.ARM        = 1'b1;
        tick();
        bus.ARM = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            {bus.probe0, bus.probe1} = 5'(k);
            tick();
            if (k == 16) begin
                checks++;
                if ({bus.ARMED, bus.TRIGGERED} !== 2'b10) begin
                    errors++;
                    $display("FAIL m0_wait got %b want 10",
                             {bus.ARMED, bus.TRIGGERED});
                end
            end
            if (k == 17) begin
                checks++;
                if ({bus.ARMED, bus.TRIGGERED} !== 2'b01) begin
                    errors++;
                    $display("FAIL m0_trig got %b want 01",
                             {bus.ARMED, bus.TRIGGERED});
                end
            end
            if (k == 63) begin
                checks++;
                if (bus.DONE !== 1'b0) begin
                    errors++;
                    $display("FAIL m0_early got %b want 0", bus.DONE);
                end
            end
        end
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL m0_done got %b want 1", bus.DONE);
        end
        bus.RD_ADDR = 6'd0;
        tick();
        checks++;
        if (bus.RD_DATA !== 5'h01) begin
            errors++;
            $display("FAIL m0_rd0 got %h want 01", bus.RD_DATA);
        end
        bus.RD_ADDR = 6'd16;
        tick();
        checks++;
        if (bus.RD_DATA !== 5'h11) begin
            errors++;
            $display("FAIL m0_rd16 got %h want 11", bus.RD_DATA);
        end
        bus.RD_ADDR = 6'd63;
        tick();
        checks++;
        if (bus.RD_DATA !== 5'h00) begin
            errors++;
            $display("FAIL m0_rd63 got %h want 00", bus.RD_DATA);
        end
    endtask

    task automatic test_no_trigger();
        int viol = 0;
        bus.TRIG_MASK  = 5'h1F;
        bus.TRIG_VALUE = 5'h1A;
        {bus.probe0, bus.probe1} = 5'h1A;
        bus.ARM = 1'b1;
        tick();
        bus.ARM = 1'b0;
        checks++;
        if ({bus.ARMED, bus.DONE} !== 2'b10) begin
            errors++;
            $display("FAIL nt_rearm got %b want 10",
                     {bus.ARMED, bus.DONE});
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
        end
        {bus.probe0, bus.probe1} = 5'h00;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bus.TRIGGERED !== 1'b0 || bus.ARMED !== 1'b1) viol++;
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL nt_hold got %0d bad cycles want 0", viol);
        end
    endtask

    task automatic test_reset_post();
        int seen = 0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        bus.TRIG_MASK = 5'h00;
        bus.ARM       = 1'b1;
        tick();
        bus.ARM = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
        end
        checks++;
        if (bus.TRIGGERED !== 1'b1) begin
            errors++;
            $display("FAIL rp_inpost got %b want 1", bus.TRIGGERED);
        end
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if ({bus.ARMED, bus.TRIGGERED, bus.DONE} !== 3'b000) begin
            errors++;
            $display("FAIL rp_abort got %b want 000",
                     {bus.ARMED, bus.TRIGGERED, bus.DONE});
        end
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.DONE !== 1'b0 || bus.ARMED !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rp_idle got %0d bad cycles want 0", seen);
        end
        bus.ARM = 1'b1;
        tick();
        bus.ARM = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
        end
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL rp_restart got %b want 1", bus.DONE);
        end
    endtask

    task automatic test_arm_held();
        bus.TRIG_MASK = 5'h00;
        bus.ARM       = 1'b1;
        tick();
        checks++;
        if ({bus.ARMED, bus.DONE} !== 2'b10) begin
            errors++;
            $display("FAIL ah_rearm got %b want 10",
                     {bus.ARMED, bus.DONE});
        end
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 63) begin
                checks++;
                if ({bus.TRIGGERED, bus.DONE} !== 2'b10) begin
                    errors++;
                    $display("FAIL ah_post got %b want 10",
                             {bus.TRIGGERED, bus.DONE});
                end
            end
        end
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL ah_done got %b want 1", bus.DONE);
        end
        tick();
        checks++;
        if ({bus.ARMED, bus.TRIGGERED, bus.DONE} !== 3'b100) begin
            errors++;
            $display("FAIL ah_restart got %b want 100",
                     {bus.ARMED, bus.TRIGGERED, bus.DONE});
        end
        bus.ARM = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_mask0();
        test_no_trigger();
        test_reset_post();
        test_arm_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ila_capture.md
ILA_CAPTURE -- requirements
Module: ila_capture

Interface
REQ-001 Parameter DEPTH, default 64, capture buffer depth in samples (power of two, >= 8).
REQ-002 Parameter PRE_TRIG, default 16, samples retained before the trigger sample (1 .. DEPTH-2).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 probe0  input  1  probe bit, sample bit [4].
REQ-006 probe1  input  4  probe bus, sample bits [3:0].
REQ-007 ARM  input  1  level sampled each edge; starts acquisition.
REQ-008 TRIG_MASK  input  5  per-bit trigger compare enable over {probe0,probe1}.
REQ-009 TRIG_VALUE  input  5  trigger compare value over {probe0,probe1}.
REQ-010 RD_ADDR  input  log2(DEPTH)  readout index, 0 = oldest captured sample.
REQ-011 RD_DATA  output  5  captured sample {probe0,probe1} at RD_ADDR, registered.
REQ-012 ARMED  output  1  high in PRETRIG and WAIT states.
REQ-013 TRIGGERED  output  1  high in POST and DONE states.
REQ-014 DONE  output  1  high in DONE state.

Function
REQ-015 Sample = {probe0,probe1}, taken directly at each rising CLK edge, no input register.
REQ-016 States: IDLE, PRETRIG, WAIT, POST, DONE; encoded in a registered state variable.
REQ-017 IDLE or DONE with ARM=1 -> PRETRIG; write pointer and counters cleared; DONE, TRIGGERED drop next cycle.
REQ-018 ARM is ignored in PRETRIG, WAIT, POST.
REQ-019 PRETRIG: write one sample per edge; after PRE_TRIG samples -> WAIT; trigger condition ignored in PRETRIG.
REQ-020 WAIT: write one sample per edge (circular, pointer wraps mod DEPTH); on an edge where (sample & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK), that sample is written and state -> POST.
REQ-021 TRIG_MASK = 0 triggers on the first WAIT edge.
REQ-022 POST: write DEPTH-PRE_TRIG-1 further samples, then -> DONE; no writes in IDLE or DONE.
REQ-023 On DONE the buffer holds the last DEPTH samples; the oldest index is latched as the write pointer after the final write.
REQ-024 RD_DATA updates one cycle after RD_ADDR to mem[(oldest + RD_ADDR) mod DEPTH]; trigger sample appears at RD_ADDR = PRE_TRIG.
REQ-025 RD_DATA is valid only in DONE; contents in other states are unspecified but deterministic.
REQ-026 Memory: DEPTH x 5 bits, single write port, single registered read port; inferable as RAM.

Reset
REQ-027 RESET=1 forces IDLE, write pointer, counters, oldest index, RD_DATA to 0, ARMED=TRIGGERED=DONE=0, immediately and independent of CLK.
REQ-028 Memory contents are not cleared by RESET.
REQ-029 Reset mid-acquisition aborts capture; a new ARM is required after release.

Verification
REQ-030 Assert RESET with clock running -> ARMED=0, TRIGGERED=0, DONE=0, RD_DATA=5'b00000 without waiting for an edge.
REQ-031 DEPTH=64, PRE_TRIG=16, TRIG_MASK=5'b01111, TRIG_VALUE=5'b00101, probe0=0, probe1 counts 0..15 repeating, ARM pulse -> trigger on first probe1=5 after 16 pretrigger samples; DONE 47 edges later; RD_ADDR=16 -> 5'b00101, RD_ADDR=15 -> 5'b00100, RD_ADDR=17 -> 5'b00110.
REQ-032 TRIG_MASK=0, ARM high at edge n -> samples at n+1..n+16 pretrigger, trigger at n+17, DONE high after edge n+64; RD_ADDR=0 returns sample of edge n+1.
REQ-033 Trigger value present only during PRETRIG, absent afterwards -> ARMED stays 1, TRIGGERED stays 0 indefinitely.
REQ-034 RESET pulse during POST -> immediately IDLE, TRIGGERED=0, DONE never asserts; subsequent ARM restarts normally.
REQ-035 ARM held high through POST -> no restart, DONE asserts on schedule; ARM in DONE -> DONE=0 next cycle, ARMED=1.
